// File: rtl/mem_access_unit.sv
// Load/store unit between the M stage and a word-wide bus with variable-latency ack.
// Builds byte-enabled writes, aligns/extends loads, stalls the pipeline and times out silent slaves.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallMem,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [29:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_reg, state_next;

   logic        req_reg, we_reg;
   logic [29:0] addr_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [1:0]  off_reg;
   logic [2:0]  f3_reg;
   logic [7:0]  cnt_reg;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        aligned, mem_op, acc, is_write, timeout;
   logic [3:0]  sb_be, be_next;
   logic [31:0] wdata_next, load_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign mem_op   = MemReadM | MemWriteM;
   assign is_write = MemWriteM;
   assign acc      = mem_op & aligned;
   assign timeout  = (cnt_reg == TO_LAST);

   always_comb begin
      aligned = 1'b0;
      case (funct3M)
         3'b000, 3'b100: aligned = 1'b1;
         3'b001, 3'b101: aligned = ~ALUResultM[0];
         3'b010:         aligned = (ALUResultM[1:0] == 2'b00);
         default:        aligned = 1'b0;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign sb_be[gi] = (ALUResultM[1:0] == 2'(gi));
      end
   endgenerate

   // Stores replicate data across lanes so the slave only needs the enables.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = '0;
      if (is_write) begin
         case (funct3M[1:0])
            2'b00: begin
               be_next    = sb_be;
               wdata_next = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_next    = ALUResultM[1] ? 4'b1100 : 4'b0011;
               wdata_next = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_next    = 4'b1111;
               wdata_next = WriteDataM;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (acc) state_next = BUSY;
         BUSY:    if (bus_ack || timeout) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         be_reg    <= '0;
         wdata_reg <= '0;
         off_reg   <= '0;
         f3_reg    <= '0;
         cnt_reg   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (acc) begin
                  req_reg   <= 1'b1;
                  we_reg    <= is_write;
                  addr_reg  <= ALUResultM[31:2];
                  be_reg    <= be_next;
                  wdata_reg <= wdata_next;
                  off_reg   <= ALUResultM[1:0];
                  f3_reg    <= funct3M;
                  cnt_reg   <= '0;
               end
            end
            BUSY: begin
               if (bus_ack || timeout) begin
                  // Ack has priority over a timeout landing in the same cycle.
                  rdata_q   <= (bus_ack && !we_reg) ? bus_rdata : 32'h0;
                  err_q     <= ~bus_ack;
                  req_reg   <= 1'b0;
                  we_reg    <= 1'b0;
                  addr_reg  <= '0;
                  be_reg    <= '0;
                  wdata_reg <= '0;
               end else if (cnt_reg != 8'hFF) begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_sel = rdata_q[{off_reg, 3'b000} +: 8];
      half_sel = off_reg[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (f3_reg)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {24'h0, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'h0, half_sel};
         default: load_val = rdata_q;
      endcase
   end

   always_comb begin
      ReadDataM = '0;
      if (state_reg == DONE) ReadDataM = load_val;
   end

   assign StallMem  = ((state_reg == IDLE) && acc) || (state_reg == BUSY);
   assign MisalignM = (state_reg == IDLE) && mem_op && !aligned;
   assign BusErrM   = (state_reg == DONE) && err_q;
   assign bus_req   = req_reg;
   assign bus_we    = we_reg;
   assign bus_addr  = addr_reg;
   assign bus_be    = be_reg;
   assign bus_wdata = wdata_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit: each vector drives one access, a bus slave
// acks in a chosen BUSY cycle, and the scoreboard checks bus fields, latency and results.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemReadM = 1'b0, MemWriteM = 1'b0;
   logic [2:0]  funct3M = '0;
   logic [31:0] ALUResultM = '0, WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic        StallMem, MisalignM, BusErrM;
   logic        bus_req, bus_we;
   logic [29:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallMem(StallMem), .MisalignM(MisalignM), .BusErrM(BusErrM),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mr, mw;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdata;
      int          ack_k;      // BUSY cycle of ack; 0 = never
      logic        e_we;
      logic [29:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_rd;
      logic        e_err, e_mis, chk_rd;
      int          e_stall, e_req;
   } vec_t;

   vec_t vt[18];
   vec_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge starting the following IDLE cycle.
   task automatic run_vec(input int idx, input vec_t v);
      vec_t e;
      int   stalls = 0, reqs = 0;
      bit   done = 0;
      MemReadM = v.mr; MemWriteM = v.mw; funct3M = v.f3;
      ALUResultM = v.addr; WriteDataM = v.wd; bus_rdata = v.rdata; bus_ack = 1'b0;
      sb_q.push_back(v);
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (StallMem) begin
            stalls++;
            if (bus_req) begin
               reqs++;
               chk($sformatf("v%0d bus_we", idx),    32'(bus_we),   32'(v.e_we));
               chk($sformatf("v%0d bus_addr", idx),  32'(bus_addr), 32'(v.e_addr));
               chk($sformatf("v%0d bus_be", idx),    32'(bus_be),   32'(v.e_be));
               chk($sformatf("v%0d bus_wdata", idx), bus_wdata,     v.e_wdata);
            end
            bus_ack = bus_req && (reqs == v.ack_k);
            @(negedge clk);
         end else begin
            done = 1;
         end
      end
      e = sb_q.pop_front();
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL v%0d completion: still stalled after 40 cycles, expected %0d stalls", idx, e.e_stall);
      end else begin
         if (e.chk_rd) chk($sformatf("v%0d ReadDataM", idx), ReadDataM, e.e_rd);
         chk($sformatf("v%0d BusErrM", idx),   32'(BusErrM),   32'(e.e_err));
         chk($sformatf("v%0d MisalignM", idx), 32'(MisalignM), 32'(e.e_mis));
         chk($sformatf("v%0d stalls", idx),    32'(stalls),    32'(e.e_stall));
         chk($sformatf("v%0d req_cycles", idx), 32'(reqs),     32'(e.e_req));
         chk($sformatf("v%0d bus_idle", idx),
             {bus_req, bus_we, bus_be, bus_addr[25:0]}, 32'h0);
         chk($sformatf("v%0d bus_wdata_idle", idx), bus_wdata, 32'h0);
      end
      @(negedge clk);
      bus_ack = 1'b0;
      MemReadM = 1'b0; MemWriteM = 1'b0;
   endtask

   initial begin
      //         mr mw  f3      addr        wd            rdata        k  we e_addr  be     e_wdata       e_rd        err mis chk st rq
      vt[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 1, 30'h40, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0, 0, 2, 1};
      vt[1]  = '{0, 1, 3'b000, 32'h203, 32'h12345678, 32'h0,        2, 1, 30'h80, 4'h8, 32'h78787878, 32'h0,        0, 0, 0, 3, 2};
      vt[2]  = '{1, 0, 3'b000, 32'h202, 32'h0,        32'h80FF7F01, 3, 0, 30'h80, 4'hF, 32'h0,        32'hFFFFFFFF, 0, 0, 1, 4, 3};
      vt[3]  = '{1, 0, 3'b100, 32'h201, 32'h0,        32'h80FF7F01, 3, 0, 30'h80, 4'hF, 32'h0,        32'h0000007F, 0, 0, 1, 4, 3};
      vt[4]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 0, 30'h40, 4'hF, 32'h0,        32'hFFFF8001, 0, 0, 1, 2, 1};
      vt[5]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80011234, 1, 0, 30'h40, 4'hF, 32'h0,        32'h00008001, 0, 0, 1, 2, 1};
      vt[6]  = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 0, 30'h0,  4'h0, 32'h0,        32'h0,        0, 1, 1, 0, 0};
      vt[7]  = '{0, 1, 3'b001, 32'h0FF, 32'hFFFF,     32'h0,        1, 0, 30'h0,  4'h0, 32'h0,        32'h0,        0, 1, 1, 0, 0};
      vt[8]  = '{1, 0, 3'b010, 32'h010, 32'h0,        32'hDEADDEAD, 0, 0, 30'h4,  4'hF, 32'h0,        32'h0,        1, 0, 1, 5, 4};
      vt[9]  = '{1, 0, 3'b010, 32'h104, 32'h0,        32'h0BADF00D, 2, 0, 30'h41, 4'hF, 32'h0,        32'h0BADF00D, 0, 0, 1, 3, 2};
      vt[10] = '{0, 1, 3'b001, 32'h202, 32'hAAAA5555, 32'h0,        1, 1, 30'h80, 4'hC, 32'h55555555, 32'h0,        0, 0, 0, 2, 1};
      vt[11] = '{0, 0, 3'b010, 32'h123, 32'h0,        32'h0,        0, 0, 30'h0,  4'h0, 32'h0,        32'h0,        0, 0, 1, 0, 0};
      vt[12] = '{1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF7F01, 1, 0, 30'h80, 4'hF, 32'h0,        32'hFFFFFF80, 0, 0, 1, 2, 1};
      vt[13] = '{1, 0, 3'b101, 32'h100, 32'h0,        32'h80FF7F01, 2, 0, 30'h40, 4'hF, 32'h0,        32'h00007F01, 0, 0, 1, 3, 2};
      vt[14] = '{1, 1, 3'b010, 32'h008, 32'h01020304, 32'h0,        1, 1, 30'h2,  4'hF, 32'h01020304, 32'h0,        0, 0, 0, 2, 1};
      vt[15] = '{1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 0, 30'h0,  4'h0, 32'h0,        32'h0,        0, 1, 1, 0, 0};
      vt[16] = '{0, 1, 3'b000, 32'h201, 32'h0000CDAB, 32'h0,        1, 1, 30'h80, 4'h2, 32'hABABABAB, 32'h0,        0, 0, 0, 2, 1};
      vt[17] = '{1, 0, 3'b010, 32'h020, 32'h0,        32'h11223344, 4, 0, 30'h8,  4'hF, 32'h0,        32'h11223344, 0, 0, 1, 5, 4};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst bus", {bus_req, bus_we, bus_be, bus_addr[25:0]}, 32'h0);
      chk("rst wdata", bus_wdata, 32'h0);
      chk("rst flags", {29'h0, StallMem, MisalignM, BusErrM}, 32'h0);
      chk("rst ReadDataM", ReadDataM, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         run_vec(i, vt[i]);
         $display("vec %0d: f3=%b addr=0x%08h rd=0x%08h err=%0b mis=%0b", i, vt[i].f3, vt[i].addr,
                  vt[i].e_rd, vt[i].e_err, vt[i].e_mis);
      end

      // Reset asserted in BUSY cycle 2 of a fresh access
      MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h30; bus_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre-rst bus_req", 32'(bus_req), 32'h1);
      MemReadM = 1'b0;
      rst = 1'b0;
      #1;
      chk("async rst bus_req", 32'(bus_req), 32'h0);
      chk("async rst StallMem", 32'(StallMem), 32'h0);
      chk("async rst bus_be", 32'(bus_be), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_vec(100, vt[0]);
      $display("reset recovery: sw after mid-BUSY reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
